// File: rtl/uart_ctrl_multi.sv
// uart_ctrl_multi: serialises DATA_BYTES-wide words into single-byte AXI-Lite writes to a UART TX register,
// optionally polling the UART status register until TX is not full before each byte.
module uart_ctrl_multi #(
   parameter int         DATA_BYTES  = 2,
   parameter bit         MSB_FIRST   = 1'b1,
   parameter bit         POLL_STATUS = 1'b1,
   parameter logic [3:0] TX_ADDR     = 4'h4,
   parameter logic [3:0] STAT_ADDR   = 4'h8,
   parameter int         TXFULL_BIT  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*DATA_BYTES-1:0] data,
   input  logic                    valid,
   output logic                    ready,
   output logic [3:0]              awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [7:0]              wdata,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [3:0]              araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [7:0]              rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    done,
   output logic                    err,
   input  logic                    err_clr
);
   localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WRITE, RESP} state_t;
   localparam state_t FIRST = POLL_STATUS ? POLL_AR : WRITE;
   state_t                  state_q, state_d;
   logic [8*DATA_BYTES-1:0] data_q, data_d;
   logic [CW-1:0]           cnt_q, cnt_d, idx;
   logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                    ready_q, done_q, done_d, err_q, err_d;
   logic                    rdata_unused;
   assign rdata_unused = ^rdata;
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      done_d    = 1'b0;
      err_d     = err_clr ? 1'b0 : err_q;
      case (state_q)
         IDLE: if (valid && ready_q) begin
            data_d  = data;
            cnt_d   = '0;
            state_d = FIRST;
         end
         POLL_AR: if (arready) state_d = POLL_R;
         POLL_R: if (rvalid) begin
            if (rresp != 2'b00) err_d = 1'b1;
            state_d = (rdata[TXFULL_BIT] && rresp == 2'b00) ? POLL_AR : WRITE;
         end
         WRITE: begin
            // AW and W complete independently; leave only once both have handshaken
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: if (bvalid) begin
            if (bresp != 2'b00) err_d = 1'b1;
            if (cnt_q == CW'(DATA_BYTES - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = FIRST;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         cnt_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ready_q   <= (state_d == IDLE);
         done_q    <= done_d;
         err_q     <= err_d;
      end
   assign idx     = MSB_FIRST ? CW'(DATA_BYTES - 1) - cnt_q : cnt_q;
   assign awvalid = (state_q == WRITE) && !aw_done_q;
   assign wvalid  = (state_q == WRITE) && !w_done_q;
   assign awaddr  = awvalid ? TX_ADDR : 4'h0;
   assign wdata   = wvalid ? 8'(data_q >> {idx, 3'b000}) : 8'h00;
   assign arvalid = (state_q == POLL_AR);
   assign araddr  = arvalid ? STAT_ADDR : 4'h0;
   assign rready  = (state_q == POLL_R);
   assign bready  = (state_q == RESP);
   assign ready   = ready_q;
   assign done    = done_q;
   assign err     = err_q;
endmodule

// File: tb/tb_uart_ctrl_multi.sv
// tb_uart_ctrl_multi: drives an MSB-first/no-poll and an LSB-first/polling instance with random words
// against a latency-configurable AXI-Lite slave; byte order and handshake rules come from a word-level model.
module tb_uart_ctrl_multi;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] data0 = '0;
   logic [31:0] data1 = '0;
   logic        valid[2], ready[2], awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
   logic        arvalid[2], arready[2], rvalid[2], rready[2], done[2], err[2], err_clr[2];
   logic [3:0]  awaddr[2], araddr[2];
   logic [7:0]  wdata[2], rdata[2];
   logic [1:0]  bresp[2], rresp[2];
   int          checks = 0, failures = 0;
   int          aw_lat[2], w_lat[2], b_lat[2], ar_lat[2], r_lat[2], berr_at[2], full_until[2];
   logic [1:0]  rerr[2];
   int          aww[2], ww[2], bw[2], arw[2], rw[2], ob[2], rp[2];
   int          awn[2], wn[2], bn[2], arn[2], rn[2], donen[2], brc[2], viol[2];
   logic        awp[2], wp[2], lastfull[2], pav[2], pwv[2], parv[2];
   logic [3:0]  paa[2], par[2];
   logic [7:0]  pwd[2];
   logic [7:0]  wlog[2][1024];
   int          ar_at_aw[2][1024];

   always #5 clk = ~clk;

   uart_ctrl_multi #(.DATA_BYTES(2), .MSB_FIRST(1'b1), .POLL_STATUS(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .data(data0), .valid(valid[0]), .ready(ready[0]),
      .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]), .wdata(wdata[0]), .wvalid(wvalid[0]),
      .wready(wready[0]), .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]), .araddr(araddr[0]),
      .arvalid(arvalid[0]), .arready(arready[0]), .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]),
      .rready(rready[0]), .done(done[0]), .err(err[0]), .err_clr(err_clr[0]));

   uart_ctrl_multi #(.DATA_BYTES(4), .MSB_FIRST(1'b0), .POLL_STATUS(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .data(data1), .valid(valid[1]), .ready(ready[1]),
      .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]), .wdata(wdata[1]), .wvalid(wvalid[1]),
      .wready(wready[1]), .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]), .araddr(araddr[1]),
      .arvalid(arvalid[1]), .arready(arready[1]), .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]),
      .rready(rready[1]), .done(done[1]), .err(err[1]), .err_clr(err_clr[1]));

   // Slave and protocol monitor: at each negedge choose the slave's responses, then log the handshakes
   // that the following posedge will complete (DUT outputs depend only on its registered state).
   always @(negedge clk)
      for (int k = 0; k < 2; k++)
         if (!rst_n) begin
            awready[k] = 0; wready[k] = 0; bvalid[k] = 0; arready[k] = 0; rvalid[k] = 0;
            bresp[k] = 0; rresp[k] = 0; rdata[k] = 0;
            aww[k] = 0; ww[k] = 0; bw[k] = 0; arw[k] = 0; rw[k] = 0; ob[k] = 0; rp[k] = 0;
            awp[k] = 0; wp[k] = 0; lastfull[k] = 0; pav[k] = 0; pwv[k] = 0; parv[k] = 0;
         end else begin
            if (pav[k] && (!awvalid[k] || awaddr[k] !== paa[k])) viol[k]++;
            if (pwv[k] && (!wvalid[k] || wdata[k] !== pwd[k])) viol[k]++;
            if (parv[k] && (!arvalid[k] || araddr[k] !== par[k])) viol[k]++;
            bvalid[k]  = ob[k] > 0 && bw[k] >= b_lat[k];
            bresp[k]   = (bvalid[k] && bn[k] == berr_at[k]) ? 2'b10 : 2'b00;
            rvalid[k]  = rp[k] > 0 && rw[k] >= r_lat[k];
            rdata[k]   = (rvalid[k] && rn[k] < full_until[k]) ? 8'h08 : 8'h00;
            rresp[k]   = rvalid[k] ? rerr[k] : 2'b00;
            awready[k] = awvalid[k] && aww[k] >= aw_lat[k];
            wready[k]  = wvalid[k] && ww[k] >= w_lat[k];
            arready[k] = arvalid[k] && arw[k] >= ar_lat[k];
            if (awvalid[k] && awready[k]) begin
               if (awp[k] || ob[k] > 0 || awaddr[k] !== 4'h4 || lastfull[k]) viol[k]++;
               ar_at_aw[k][awn[k] % 1024] = arn[k];
               awn[k]++; awp[k] = 1; aww[k] = 0;
            end else if (awvalid[k]) aww[k]++;
            if (wvalid[k] && wready[k]) begin
               if (wp[k] || ob[k] > 0) viol[k]++;
               wlog[k][wn[k] % 1024] = wdata[k];
               wn[k]++; wp[k] = 1; ww[k] = 0;
            end else if (wvalid[k]) ww[k]++;
            if (bvalid[k] && bready[k]) begin bn[k]++; ob[k]--; bw[k] = 0; end
            else if (ob[k] > 0 && !bvalid[k]) bw[k]++;
            if (awp[k] && wp[k]) begin ob[k]++; awp[k] = 0; wp[k] = 0; end
            if (bready[k]) brc[k]++;
            if (rvalid[k] && rready[k]) begin
               lastfull[k] = rdata[k][3] && rresp[k] == 2'b00;
               rn[k]++; rp[k]--; rw[k] = 0;
            end else if (rp[k] > 0 && !rvalid[k]) rw[k]++;
            if (arvalid[k] && arready[k]) begin arn[k]++; rp[k]++; arw[k] = 0; end
            else if (arvalid[k]) arw[k]++;
            if (done[k]) donen[k]++;
            pav[k] = awvalid[k] && !awready[k]; paa[k] = awaddr[k];
            pwv[k] = wvalid[k] && !wready[k];   pwd[k] = wdata[k];
            parv[k] = arvalid[k] && !arready[k]; par[k] = araddr[k];
         end

   function automatic logic [7:0] exp_byte(input int k, input logic [63:0] d, input int i);
      int nb  = k ? 4 : 2;
      int pos = k ? i : nb - 1 - i;
      return 8'((d >> (8 * pos)) & 64'hff);
   endfunction

   function automatic logic [23:0] outs(input int k);
      return {ready[k], awvalid[k], wvalid[k], bready[k], arvalid[k], rready[k], done[k], err[k],
              awaddr[k], araddr[k], wdata[k]};
   endfunction

   task automatic set_data(input int k, input logic [63:0] d);
      if (k == 0) data0 = d[15:0]; else data1 = d[31:0];
   endtask

   task automatic set_lat(input int k, input int a, input int w, input int b, input int ar, input int r);
      aw_lat[k] = a; w_lat[k] = w; b_lat[k] = b; ar_lat[k] = ar; r_lat[k] = r;
   endtask

   // Streams n words back-to-back, holding valid with junk data while busy, then checks every byte.
   task automatic run_words(input int k, input int n, input logic [63:0] w0, input bit use0, input string tag);
      logic [63:0] d;
      logic [7:0]  expq[$];
      int nb = k ? 4 : 2;
      int wb = wn[k], db = donen[k], t;
      for (int j = 0; j < n; j++) begin
         d = (j == 0 && use0) ? w0 : {$urandom, $urandom};
         for (int i = 0; i < nb; i++) expq.push_back(exp_byte(k, d, i));
         set_data(k, d);
         valid[k] = 1'b1;
         t = 0;
         while (!ready[k] && t < 200) begin @(negedge clk); #1; t++; end
         @(posedge clk); #1;
         set_data(k, {$urandom, $urandom});
         t = 0;
         while (donen[k] < db + j + 1 && t < 3000) begin @(negedge clk); #1; t++; end
         checks++;
         if (donen[k] != db + j + 1) begin
            failures++;
            $display("FAIL %s done word %0d: got %0d pulses, want %0d", tag, j, donen[k] - db, j + 1);
         end
      end
      valid[k] = 1'b0;
      repeat (4) @(negedge clk); #1;
      checks++;
      if (donen[k] - db != n || wn[k] - wb != n * nb) begin
         failures++;
         $display("FAIL %s counts: got done=%0d bytes=%0d, want done=%0d bytes=%0d", tag, donen[k] - db, wn[k] - wb, n, n * nb);
      end
      for (int i = 0; i < expq.size(); i++) begin
         checks++;
         if (wn[k] - wb <= i || wlog[k][(wb + i) % 1024] !== expq[i]) begin
            failures++;
            $display("FAIL %s byte %0d: got %h, want %h", tag, i, wlog[k][(wb + i) % 1024], expq[i]);
         end
      end
      checks++;
      if (viol[k] !== 0) begin
         failures++;
         $display("FAIL %s protocol: got %0d violations, want 0", tag, viol[k]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (outs(k) !== 24'h0) begin failures++; $display("FAIL reset_outs[%0d]: got %h, want 000000", k, outs(k)); end
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ready[k] !== 1'b0) begin failures++; $display("FAIL ready_before_edge[%0d]: got %b, want 0", k, ready[k]); end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ready[k] !== 1'b1) begin failures++; $display("FAIL ready_after_edge[%0d]: got %b, want 1", k, ready[k]); end
      end
   endtask

   task automatic test_throughput;
      int wb = wn[0], bb = brc[0], db = donen[0], c = 0;
      set_lat(0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      data0 = 16'h4f3e;
      valid[0] = 1'b1;
      while (!ready[0] && c < 50) begin @(negedge clk); #1; c++; end
      @(posedge clk); #1;
      valid[0] = 1'b0;
      c = 0;
      while (!done[0] && c < 50) begin @(posedge clk); #1; c++; end
      checks++;
      if (c != 4) begin failures++; $display("FAIL throughput cycles: got %0d, want 4", c); end
      @(posedge clk); #1;
      checks++;
      if (done[0] !== 1'b0 || ready[0] !== 1'b1) begin
         failures++; $display("FAIL done_pulse: got done=%b ready=%b, want done=0 ready=1", done[0], ready[0]);
      end
      @(negedge clk); #1;
      checks++;
      if (wn[0] - wb != 2 || wlog[0][wb % 1024] !== 8'h4f || wlog[0][(wb + 1) % 1024] !== 8'h3e) begin
         failures++;
         $display("FAIL msb_bytes: got n=%0d %h %h, want 2 4f 3e", wn[0] - wb, wlog[0][wb % 1024], wlog[0][(wb + 1) % 1024]);
      end
      checks++;
      if (donen[0] - db != 1 || brc[0] - bb != 2) begin
         failures++; $display("FAIL throughput counts: got done=%0d bready=%0d, want 1 2", donen[0] - db, brc[0] - bb);
      end
   endtask

   task automatic test_wready_lag;
      int ab = awn[0], bb = brc[0];
      set_lat(0, 0, 3, 0, 0, 0);
      run_words(0, 3, 64'h0, 1'b0, "wlag");
      checks++;
      if (awn[0] - ab != 6 || brc[0] - bb != 6) begin
         failures++; $display("FAIL wlag counts: got aw=%0d bready=%0d, want 6 6", awn[0] - ab, brc[0] - bb);
      end
      set_lat(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_err;
      int t = 0;
      berr_at[0] = bn[0];
      run_words(0, 1, 64'h0, 1'b0, "berr");
      checks++;
      if (err[0] !== 1'b1) begin failures++; $display("FAIL err_set: got %b, want 1", err[0]); end
      run_words(0, 1, 64'h0, 1'b0, "berr_sticky");
      checks++;
      if (err[0] !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b, want 1", err[0]); end
      err_clr[0] = 1'b1;
      @(negedge clk); #1;
      err_clr[0] = 1'b0;
      checks++;
      if (err[0] !== 1'b0) begin failures++; $display("FAIL err_clr: got %b, want 0", err[0]); end
      berr_at[0] = bn[0] + 1;
      set_data(0, {$urandom, $urandom});
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      while (!(bvalid[0] && bready[0] && bresp[0] != 2'b00) && t < 200) begin @(negedge clk); #1; t++; end
      err_clr[0] = 1'b1;
      @(posedge clk); #1;
      err_clr[0] = 1'b0;
      checks++;
      if (err[0] !== 1'b1 || t >= 200) begin failures++; $display("FAIL err_race: got %b (wait %0d), want 1", err[0], t); end
      repeat (6) @(negedge clk);
      berr_at[0] = -1;
   endtask

   task automatic test_lsb_order;
      set_lat(1, 0, 0, 0, 0, 0);
      full_until[1] = rn[1];
      run_words(1, 2, 64'h11223344, 1'b1, "lsb");
   endtask

   task automatic test_poll;
      int arb = arn[1], awb = awn[1];
      full_until[1] = rn[1] + 3;
      run_words(1, 1, 64'h0, 1'b0, "poll");
      checks++;
      if (ar_at_aw[1][awb % 1024] - arb != 4 || arn[1] - arb != 7) begin
         failures++;
         $display("FAIL poll ar: got %0d before first aw, %0d total, want 4 7", ar_at_aw[1][awb % 1024] - arb, arn[1] - arb);
      end
   endtask

   task automatic test_rerr;
      rerr[1] = 2'b10;
      full_until[1] = rn[1];
      run_words(1, 1, 64'h0, 1'b0, "rerr");
      checks++;
      if (err[1] !== 1'b1) begin failures++; $display("FAIL rerr: got %b, want 1", err[1]); end
      rerr[1] = 2'b00;
   endtask

   task automatic test_reset_mid;
      int ab, db, t = 0;
      set_lat(0, 0, 0, 6, 0, 0);
      set_data(0, {$urandom, $urandom});
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      while (!bready[0] && t < 100) begin @(negedge clk); #1; t++; end
      ab = awn[0]; db = donen[0];
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs(0) !== 24'h0 || t >= 100) begin failures++; $display("FAIL mid_reset_outs: got %h, want 000000", outs(0)); end
      @(negedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (ready[0] !== 1'b0) begin failures++; $display("FAIL mid_reset_ready0: got %b, want 0", ready[0]); end
      @(posedge clk); #1;
      checks++;
      if (ready[0] !== 1'b1) begin failures++; $display("FAIL mid_reset_ready1: got %b, want 1", ready[0]); end
      repeat (20) @(negedge clk); #1;
      checks++;
      if (awn[0] != ab || donen[0] != db) begin
         failures++; $display("FAIL mid_reset_resend: got aw=%0d done=%0d, want 0 0", awn[0] - ab, donen[0] - db);
      end
      set_lat(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 2; k++) begin
            set_lat(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            full_until[k] = rn[k] + $urandom_range(0, 3);
            run_words(k, 3, 64'h0, 1'b0, "b2b");
         end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         valid[k] = 1'b0; err_clr[k] = 1'b0; rerr[k] = 2'b00; berr_at[k] = -1; full_until[k] = 0;
         awn[k] = 0; wn[k] = 0; bn[k] = 0; arn[k] = 0; rn[k] = 0; donen[k] = 0; brc[k] = 0; viol[k] = 0;
         set_lat(k, 0, 0, 0, 0, 0);
      end
      test_reset;
      test_throughput;
      test_wready_lag;
      test_err;
      test_lsb_order;
      test_poll;
      test_rerr;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_ctrl_multi.md
UART_CTRL_MULTI -- requirements
Module: uart_ctrl_multi

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2, number of bytes per input word (1..8).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 sends byte DATA_BYTES-1 first, 0 sends byte 0 first.
REQ-003 SHALL have parameter POLL_STATUS, default 1; 1 polls the UART status register before each byte write.
REQ-004 SHALL have parameters TX_ADDR (4'h4) and STAT_ADDR (4'h8), and TXFULL_BIT (3).
REQ-005 SHALL have port clk  in  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports data  in  8*DATA_BYTES  word; valid  in  1; ready  out  1.
REQ-008 SHALL have AXI-Lite write ports awaddr out 4, awvalid out 1, awready in 1, wdata out 8, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.
REQ-009 SHALL have AXI-Lite read ports araddr out 4, arvalid out 1, arready in 1, rdata in 8, rresp in 2, rvalid in 1, rready out 1.
REQ-010 SHALL have outputs done  out  1  one-cycle pulse per completed word; err  out  1  sticky response error; err_clr  in  1  clears err.

Function
REQ-011 SHALL implement states IDLE, POLL_AR, POLL_R, WRITE, RESP.
REQ-012 SHALL register ready, high only in IDLE; valid&&ready captures data into a shift register and byte counter=0.
REQ-013 SHALL ignore data/valid changes outside IDLE.
REQ-014 From IDLE on accept: go to POLL_AR if POLL_STATUS=1, else WRITE.
REQ-015 POLL_AR: arvalid=1, araddr=STAT_ADDR; on arready go POLL_R.
REQ-016 POLL_R: rready=1; on rvalid with rdata[TXFULL_BIT]=1 return to POLL_AR; otherwise go WRITE.
REQ-017 POLL_R rvalid with rresp!=0 SHALL set err and proceed to WRITE.
REQ-018 WRITE: awvalid=wvalid=1 on entry, awaddr=TX_ADDR, wdata=current byte per MSB_FIRST.
REQ-019 awvalid and wvalid SHALL each drop independently on their own handshake; go RESP when both done, including same-cycle or either order.
REQ-020 Once asserted, every *valid SHALL hold with stable payload until its handshake.
REQ-021 RESP: bready=1; on bvalid, bresp!=0 sets err; increment byte counter.
REQ-022 After bvalid, if more bytes remain go to POLL_AR/WRITE per POLL_STATUS; else pulse done one cycle and return to IDLE (ready=1 next cycle).
REQ-023 Byte counter width SHALL be max(1,$clog2(DATA_BYTES)); last byte is count DATA_BYTES-1, no wrap.
REQ-024 err_clr SHALL clear err; a simultaneous error event wins (err stays 1).
REQ-025 With POLL_STATUS=0 and slave ready/valid in same cycle as request, each byte SHALL take exactly 2 cycles (WRITE, RESP).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, ready=0, awvalid=wvalid=bready=arvalid=rready=0, done=0, err=0, counter=0, awaddr=araddr=0, wdata=0.
REQ-027 ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-028 Reset mid-transfer SHALL abandon the word; no byte of it is resent after reset.

Verification
REQ-029 DATA_BYTES=2, MSB_FIRST=1, POLL_STATUS=0, data=16'h4f3e -> writes 8'h4f then 8'h3e to addr 4'h4, done pulses once, ready returns.
REQ-030 MSB_FIRST=0, DATA_BYTES=4, data=32'h11223344 -> wdata order 44,33,22,11.
REQ-031 POLL_STATUS=1, status rdata=8'h08 for 3 reads then 8'h00 -> 4 AR handshakes before first AW, no AW while full.
REQ-032 Slave asserts wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, one bready cycle per byte.
REQ-033 bresp=2'b10 on byte 0 -> err=1, remaining bytes still sent; err_clr pulse -> err=0.
REQ-034 rst_n low during RESP of byte 0 -> all valids 0 immediately, ready=1 on first edge after release, no further AW.
